// File: rtl/wb_intercon_pkg.sv
// wb_intercon_pkg: shared types and helpers for the Wishbone interconnect and its address decoder.
package wb_intercon_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
   localparam logic [63:0] ERR_DATA = '0;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic logic addr_match(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] mask);
      return (addr & mask) == (base & mask);
   endfunction
endpackage

// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder: combinational base/mask address decoder; the lowest matching slave index wins.
module wb_addr_decoder
   import wb_intercon_pkg::*;
#(
   parameter int NUM_SLAVE = 4,
   parameter int ADDR_W = 32,
   parameter int IDX_W = idx_w(NUM_SLAVE),
   parameter logic [NUM_SLAVE*ADDR_W-1:0] SLAVE_BASE = '0,
   parameter logic [NUM_SLAVE*ADDR_W-1:0] SLAVE_MASK = '0
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [IDX_W-1:0]  idx
);
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_SLAVE - 1; i >= 0; i--)
         if (addr_match(64'(addr), 64'(SLAVE_BASE[i*ADDR_W +: ADDR_W]), 64'(SLAVE_MASK[i*ADDR_W +: ADDR_W]))) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
   end
endmodule

// File: rtl/wb_intercon_tmo.sv
// wb_intercon_tmo: single-master N-slave classic Wishbone interconnect with unmapped-error and ack timeout.
// Define WB_INTERCON_ERR_STAT_EN to add the error counter / last-error-address registers.
module wb_intercon_tmo
   import wb_intercon_pkg::*;
#(
   parameter int NUM_SLAVE = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [NUM_SLAVE*ADDR_W-1:0] SLAVE_BASE = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVE*ADDR_W-1:0] SLAVE_MASK = {4{32'hFF00_0000}},
   parameter int TIMEOUT = 255
) (
   input  logic                        clk,
   input  logic                        arst,
   input  logic                        i_wbm_cyc,
   input  logic                        i_wbm_stb,
   input  logic                        i_wbm_we,
   input  logic [DATA_W/8-1:0]         i_wbm_sel,
   input  logic [ADDR_W-1:0]           i_wbm_addr,
   input  logic [DATA_W-1:0]           i_wbm_data,
   output logic [DATA_W-1:0]           o_wbm_data,
   output logic                        o_wbm_ack,
   output logic                        o_wbm_err,
   output logic [NUM_SLAVE-1:0]        o_wbs_cyc,
   output logic [NUM_SLAVE-1:0]        o_wbs_stb,
   output logic                        o_wbs_we,
   output logic [DATA_W/8-1:0]         o_wbs_sel,
   output logic [ADDR_W-1:0]           o_wbs_addr,
   output logic [DATA_W-1:0]           o_wbs_data,
   input  logic [NUM_SLAVE*DATA_W-1:0] i_wbs_data,
   input  logic [NUM_SLAVE-1:0]        i_wbs_ack
`ifdef WB_INTERCON_ERR_STAT_EN
   ,
   input  logic                        i_err_clr,
   output logic [15:0]                 o_err_cnt,
   output logic [ADDR_W-1:0]           o_err_addr
`endif
);
   localparam int IDX_W = idx_w(NUM_SLAVE);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   typedef logic [IDX_W-1:0] slv_idx_t;

   state_t             state;
   slv_idx_t           sel_idx;
   slv_idx_t           dec_idx;
   logic               dec_hit;
   logic [CNT_W-1:0]   cnt;
   logic               s_ack;
   logic [DATA_W-1:0]  s_data;

   wb_addr_decoder #(
      .NUM_SLAVE (NUM_SLAVE),
      .ADDR_W    (ADDR_W),
      .IDX_W     (IDX_W),
      .SLAVE_BASE(SLAVE_BASE),
      .SLAVE_MASK(SLAVE_MASK)
   ) u_dec (
      .addr(i_wbm_addr),
      .hit (dec_hit),
      .idx (dec_idx)
   );

   assign s_ack  = i_wbs_ack[sel_idx];
   assign s_data = i_wbs_data[int'(sel_idx)*DATA_W +: DATA_W];

   always_ff @(posedge clk or posedge arst)
      if (arst) begin
         state      <= IDLE;
         sel_idx    <= '0;
         cnt        <= '0;
         o_wbm_data <= '0;
         o_wbm_ack  <= 1'b0;
         o_wbm_err  <= 1'b0;
         o_wbs_cyc  <= '0;
         o_wbs_stb  <= '0;
         o_wbs_we   <= 1'b0;
         o_wbs_sel  <= '0;
         o_wbs_addr <= '0;
         o_wbs_data <= '0;
      end else
         case (state)
            IDLE:
               if (i_wbm_cyc && i_wbm_stb) begin
                  o_wbs_we   <= i_wbm_we;
                  o_wbs_sel  <= i_wbm_sel;
                  o_wbs_addr <= i_wbm_addr;
                  o_wbs_data <= i_wbm_data;
                  sel_idx    <= dec_idx;
                  cnt        <= '0;
                  if (dec_hit) begin
                     state     <= ACTIVE;
                     o_wbs_cyc <= NUM_SLAVE'(1) << dec_idx;
                     o_wbs_stb <= NUM_SLAVE'(1) << dec_idx;
                  end else begin
                     state      <= RESP;
                     o_wbm_err  <= 1'b1;
                     o_wbm_data <= DATA_W'(ERR_DATA);
                  end
               end
            ACTIVE: begin
               cnt <= cnt + 1'b1;
               // abort beats ack, and ack beats a timeout expiring in the same cycle
               if (!i_wbm_cyc) begin
                  state     <= IDLE;
                  o_wbs_cyc <= '0;
                  o_wbs_stb <= '0;
               end else if (s_ack) begin
                  state      <= RESP;
                  o_wbm_ack  <= 1'b1;
                  o_wbm_data <= o_wbs_we ? DATA_W'(ERR_DATA) : s_data;
                  o_wbs_cyc  <= '0;
                  o_wbs_stb  <= '0;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state      <= RESP;
                  o_wbm_err  <= 1'b1;
                  o_wbm_data <= DATA_W'(ERR_DATA);
                  o_wbs_cyc  <= '0;
                  o_wbs_stb  <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               o_wbm_ack <= 1'b0;
               o_wbm_err <= 1'b0;
               cnt       <= '0;
            end
         endcase

`ifdef WB_INTERCON_ERR_STAT_EN
   always_ff @(posedge clk or posedge arst)
      if (arst) begin
         o_err_cnt  <= '0;
         o_err_addr <= '0;
      end else if (i_err_clr) begin
         o_err_cnt  <= '0;
         o_err_addr <= '0;
      end else if (state == RESP && o_wbm_err) begin
         o_err_cnt  <= (o_err_cnt == 16'hFFFF) ? o_err_cnt : o_err_cnt + 16'd1;
         o_err_addr <= o_wbs_addr;
      end
`endif
endmodule

// File: tb/tb_wb_intercon_tmo.sv
// tb_wb_intercon_tmo: directed scoreboard bench for wb_intercon_tmo.
module tb_wb_intercon_tmo;
   logic         clk = 1'b0;
   logic         arst;
   logic         cyc, stb, we;
   logic [3:0]   sel;
   logic [31:0]  addr, wdata;
   logic [31:0]  m_data;
   logic         m_ack, m_err;
   logic [3:0]   s_cyc, s_stb;
   logic         s_we;
   logic [3:0]   s_sel;
   logic [31:0]  s_addr, s_wdata;
   logic [3:0]   s_ack;
   logic [127:0] s_data;
   logic [3:0]   ov_cyc, ov_stb, ov_sel;
   logic         ov_we, ov_mack, ov_merr;
   logic [31:0]  ov_addr, ov_wdata, ov_mdata;
`ifdef WB_INTERCON_ERR_STAT_EN
   logic         err_clr = 1'b0;
   logic [15:0]  err_cnt, ov_err_cnt;
   logic [31:0]  err_addr, ov_err_addr;
`endif

   typedef struct {logic a; logic e; logic [31:0] d; int cyc;} exp_t;
   exp_t        exp_q[$];
   int          delay[4] = '{0, 2, -1, 0};
   logic [31:0] rdata[4] = '{32'h1111_0000, 32'hCAFE_0001, 32'h2222_0002, 32'h3333_0003};
   int          scnt[4] = '{default: 0};
   int          stb_cyc[4] = '{default: 0};
   logic [3:0]  last_stb = '0, ov_last_stb = '0;
   logic [31:0] ov_last_data = '0;
   int          cyc_n = 0;
   int          checks = 0, passes = 0;

   always #5 clk = ~clk;

   wb_intercon_tmo #(.TIMEOUT(16)) u_dut (
      .clk(clk), .arst(arst),
      .i_wbm_cyc(cyc), .i_wbm_stb(stb), .i_wbm_we(we), .i_wbm_sel(sel),
      .i_wbm_addr(addr), .i_wbm_data(wdata),
      .o_wbm_data(m_data), .o_wbm_ack(m_ack), .o_wbm_err(m_err),
      .o_wbs_cyc(s_cyc), .o_wbs_stb(s_stb), .o_wbs_we(s_we), .o_wbs_sel(s_sel),
      .o_wbs_addr(s_addr), .o_wbs_data(s_wdata),
      .i_wbs_data(s_data), .i_wbs_ack(s_ack)
`ifdef WB_INTERCON_ERR_STAT_EN
      , .i_err_clr(err_clr), .o_err_cnt(err_cnt), .o_err_addr(err_addr)
`endif
   );

   // slave 0 decodes every address here, so it shadows all the others
   wb_intercon_tmo #(
      .TIMEOUT(16),
      .SLAVE_MASK({32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'h0000_0000})
   ) u_ovl (
      .clk(clk), .arst(arst),
      .i_wbm_cyc(cyc), .i_wbm_stb(stb), .i_wbm_we(we), .i_wbm_sel(sel),
      .i_wbm_addr(addr), .i_wbm_data(wdata),
      .o_wbm_data(ov_mdata), .o_wbm_ack(ov_mack), .o_wbm_err(ov_merr),
      .o_wbs_cyc(ov_cyc), .o_wbs_stb(ov_stb), .o_wbs_we(ov_we), .o_wbs_sel(ov_sel),
      .o_wbs_addr(ov_addr), .o_wbs_data(ov_wdata),
      .i_wbs_data({32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000}), .i_wbs_ack(ov_stb)
`ifdef WB_INTERCON_ERR_STAT_EN
      , .i_err_clr(1'b0), .o_err_cnt(ov_err_cnt), .o_err_addr(ov_err_addr)
`endif
   );

   assign s_data = {rdata[3], rdata[2], rdata[1], rdata[0]};

   always_comb begin
      s_ack = '0;
      for (int i = 0; i < 4; i++) s_ack[i] = s_stb[i] && (scnt[i] == delay[i]);
   end

   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      for (int i = 0; i < 4; i++) scnt[i] <= s_stb[i] ? scnt[i] + 1 : 0;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic int stb_total();
      return stb_cyc[0] + stb_cyc[1] + stb_cyc[2] + stb_cyc[3];
   endfunction

   initial forever begin
      exp_t x;
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (s_stb[i]) stb_cyc[i]++;
      if (s_stb != 0) last_stb = s_stb;
      if (ov_stb != 0) ov_last_stb = ov_stb;
      if (ov_mack) ov_last_data = ov_mdata;
      if (m_ack || m_err) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_resp: got ack=%b err=%b data=%h expected none", m_ack, m_err, m_data);
         end else begin
            x = exp_q.pop_front();
            chk("resp", 64'({m_ack, m_err, m_data}), 64'({x.a, x.e, x.d}));
            chk("latency", 64'(cyc_n), 64'(x.cyc));
         end
      end
   end

   task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic xa, input logic xe, input logic [31:0] xd, input int lat);
      bit done = 0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; sel = 4'hF; addr = a; wdata = d;
      exp_q.push_back('{xa, xe, xd, cyc_n + lat});
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         done = m_ack || m_err;
      end
      if (!done) begin
         checks++;
         $display("FAIL resp_timeout: got no ack/err for addr %h expected one", a);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      cyc = 0; stb = 0;
   endtask

   initial begin
      int b;
      arst = 1; cyc = 0; stb = 0; we = 0; sel = 0; addr = 0; wdata = 0;
      repeat (3) @(posedge clk);
      #1 arst = 0;
      @(negedge clk);
      chk("reset_zero", 64'({|s_cyc, |s_stb, s_we, |s_sel, |s_addr, |s_wdata, m_ack, m_err, |m_data}), 64'(0));

      b = stb_cyc[1];
      req(32'h0100_0010, 0, 0, 1, 0, 32'hCAFE_0001, 4); idle();
      chk("rd1_stb", 64'(last_stb), 64'(4'b0010));
      chk("rd1_stb_cycles", 64'(stb_cyc[1] - b), 64'(3));

      req(32'h0000_0100, 0, 0, 1, 0, 32'h1111_0000, 2);
      req(32'h0300_0004, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 2); idle();
      chk("wr3_addr", 64'(s_addr), 64'(32'h0300_0004));
      chk("wr3_we_data", 64'({s_we, s_wdata}), 64'({1'b1, 32'hDEAD_BEEF}));

      b = stb_total();
      req(32'h0800_0000, 1, 32'h0000_5555, 0, 1, 32'h0, 1); idle();
      chk("unmapped_no_stb", 64'(stb_total()), 64'(b));

      b = stb_cyc[2];
      req(32'h0200_0040, 0, 0, 0, 1, 32'h0, 17); idle();
      chk("tmo_stb_cycles", 64'(stb_cyc[2] - b), 64'(16));
`ifdef WB_INTERCON_ERR_STAT_EN
      chk("err_cnt", 64'(err_cnt), 64'(2));
      chk("err_addr", 64'(err_addr), 64'(32'h0200_0040));
      err_clr = 1;
      @(posedge clk); #1 err_clr = 0;
      chk("err_clr", 64'({err_cnt, err_addr}), 64'(0));
`endif

      delay[2] = 15;
      req(32'h0200_0044, 0, 0, 1, 0, 32'h2222_0002, 17); idle();

      ov_last_stb = '0; ov_last_data = '0;
      req(32'h0300_0000, 0, 0, 1, 0, 32'h3333_0003, 2); idle();
      chk("ovl_stb", 64'(ov_last_stb), 64'(4'b0001));
      chk("ovl_data", 64'(ov_last_data), 64'(32'hD000_0000));

      delay[1] = 1;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; addr = 32'h0100_0020;
      @(posedge clk);
      @(posedge clk); #1;
      cyc = 0; stb = 0;
      @(negedge clk);
      chk("abort_same_ack", 64'(s_ack[1]), 64'(1));
      @(negedge clk);
      chk("abort_stb_drop", 64'({s_cyc, s_stb}), 64'(0));
      repeat (3) @(negedge clk);
      delay[1] = 2;
      req(32'h0100_0010, 0, 0, 1, 0, 32'hCAFE_0001, 4); idle();

      delay[2] = -1;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; addr = 32'h0200_0000;
      @(posedge clk); #1;
      chk("arst_pre_stb", 64'(s_stb), 64'(4'b0100));
      arst = 1;
      #1;
      chk("arst_zero", 64'({|s_cyc, |s_stb, s_we, |s_sel, |s_addr, |s_wdata, m_ack, m_err, |m_data}), 64'(0));
      cyc = 0; stb = 0;
      @(posedge clk); #1 arst = 0;
      req(32'h0000_0008, 0, 0, 1, 0, 32'h1111_0000, 2); idle();

      repeat (5) @(posedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1);
   end
endmodule
